// File: rtl/sys_mem_sequencer_pkg.sv
// Shared types for the test-side RAM sequencer: RAM handshake state, word type,
// sequencer FSM states and the word-address helper.
package sys_mem_sequencer_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_WR,
    RUN,
    DUMP_RD,
    DUMP_OUT,
    DONE,
    ERR
  } seq_state_t;

  // Byte address of word idx above base, forced onto a word boundary.
  function automatic word_t word_addr(word_t base, word_t idx);
    return (base + (idx << 2)) & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/sys_mem_sequencer_if.sv
// Test-bench RAM port of the system block: ownership, enables, address/data and
// the RAM's handshake state. master = sequencer, slave = RAM.
interface sys_mem_sequencer_if;
  import sys_mem_sequencer_pkg::*;

  logic      tbCTRL;
  logic      WEN;
  logic      REN;
  word_t     addr;
  word_t     store;
  word_t     load;
  ramstate_t ramstate;

  modport master (
    output tbCTRL, WEN, REN, addr, store,
    input  ramstate, load
  );

  modport slave (
    input  tbCTRL, WEN, REN, addr, store,
    output ramstate, load
  );

endinterface

// File: rtl/sys_mem_sequencer.sv
// Loads a program image into RAM, releases the CPU until halt, then streams a
// RAM window out. Owns CPU reset and the RAM port outside RUN.
module sys_mem_sequencer
  import sys_mem_sequencer_pkg::*;
#(
  parameter word_t       LOAD_BASE   = 32'h0,
  parameter int unsigned LOAD_MAX    = 1024,
  parameter word_t       DUMP_BASE   = 32'h0,
  parameter int unsigned DUMP_WORDS  = 1024,
  parameter int unsigned RUN_TIMEOUT = 1000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  word_t               ld_data,
  input  logic                ld_last,
  input  logic                halt,
  sys_mem_sequencer_if.master ram,
  output logic                cpu_rst,
  output logic                dump_valid,
  input  logic                dump_ready,
  output word_t               dump_addr,
  output word_t               dump_data,
  output logic                dump_last,
  output word_t               cycles,
  output logic                done,
  output logic                err
);

  localparam int IDX_W = $clog2(LOAD_MAX + 1);
  localparam int J_W   = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

  seq_state_t       state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [J_W-1:0]   j;
  word_t            data_q;
  logic             last_q;
  word_t            dump_q;
  logic             ld_full;
  logic             j_last;

  // idx counts words already written; one more would overflow the image.
  assign ld_full = (idx == IDX_W'(LOAD_MAX));
  assign j_last  = (j == J_W'(DUMP_WORDS - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      idx    <= '0;
      j      <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      dump_q <= '0;
      cycles <= '0;
    end else begin
      state <= state_nx;
      if (state == RUN && cycles != 32'hFFFF_FFFF)
        cycles <= cycles + 32'd1;
      case (state)
        IDLE: if (start) begin
          idx <= '0;
          j   <= '0;
        end
        LD_WAIT: if (ld_valid && !ld_full) begin
          data_q <= ld_data;
          last_q <= ld_last;
        end
        LD_WR:    if (ram.ramstate == ACCESS) idx <= idx + 1'b1;
        DUMP_RD:  if (ram.ramstate == ACCESS) dump_q <= ram.load;
        DUMP_OUT: if (dump_ready && !j_last) j <= j + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    ld_ready   = 1'b0;
    cpu_rst    = 1'b1;
    ram.tbCTRL = 1'b1;
    ram.WEN    = 1'b0;
    ram.REN    = 1'b0;
    ram.addr   = '0;
    ram.store  = '0;
    dump_valid = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: if (start) state_nx = LD_WAIT;
      LD_WAIT: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nx = ld_full ? ERR : LD_WR;
      end
      LD_WR: begin
        ram.WEN   = 1'b1;
        ram.addr  = word_addr(LOAD_BASE, 32'(idx));
        ram.store = data_q;
        if (ram.ramstate == ERROR)       state_nx = ERR;
        else if (ram.ramstate == ACCESS) state_nx = last_q ? RUN : LD_WAIT;
      end
      RUN: begin
        ram.tbCTRL = 1'b0;
        cpu_rst    = 1'b0;
        // halt wins over a timeout landing on the same edge
        if (halt)                             state_nx = DUMP_RD;
        else if (cycles == RUN_TIMEOUT - 1)   state_nx = ERR;
      end
      DUMP_RD: begin
        ram.REN  = 1'b1;
        ram.addr = word_addr(DUMP_BASE, 32'(j));
        if (ram.ramstate == ERROR)       state_nx = ERR;
        else if (ram.ramstate == ACCESS) state_nx = DUMP_OUT;
      end
      DUMP_OUT: begin
        dump_valid = 1'b1;
        if (dump_ready) state_nx = j_last ? DONE : DUMP_RD;
      end
      DONE: done = 1'b1;
      ERR:  err  = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  assign dump_addr = word_addr(DUMP_BASE, 32'(j));
  assign dump_data = dump_q;
  assign dump_last = (state == DUMP_OUT) && j_last;

endmodule
